exu_seq_ctrl: RTL and testbench

- Multi-cycle execute sequencer between IDU and WBU: accepts one decoded instruction plus its EXU result, and stalls through a memory request/response for loads and stores.
- Presents one completed result per instruction to the write-back stage with a valid/ready handshake.
- Flags taken branches as redirects and detects memory-response timeouts.

---
 rtl/exu_seq_ctrl.sv | 151 +++++++++++++++
 tb/tb_exu_seq_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/exu_seq_ctrl.sv
// Execute-stage sequencer between IDU and WBU.
// Holds one instruction at a time. Loads and stores are sent through a
// memory request/response exchange, and every instruction produces one
// write-back result on a valid/ready handshake. A taken branch is flagged
// as a redirect. A memory response that never arrives ends the
// instruction with an error result.
module exu_seq_ctrl #(
    parameter int XLEN    = 32,
    parameter int TMO_W   = 8,
    parameter int TMO_MAX = 255
) (
    input  logic            clk,
    input  logic            i_rst,

    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_res,
    input  logic [XLEN-1:0] in_wdata,
    input  logic            in_is_load,
    input  logic            in_is_store,
    input  logic            in_is_brch,
    input  logic            in_brch_taken,

    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic            mem_req_wen,
    output logic [XLEN-1:0] mem_req_addr,
    output logic [XLEN-1:0] mem_req_wdata,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rsp_data,

    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_res,
    output logic            out_redirect,
    output logic            out_err,
    output logic            err_sticky
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MEM_REQ,
        S_MEM_WAIT,
        S_WB
    } state_t;

    // The wait counter starts at 0 on entry to MEM_WAIT. The wait gives up
    // in the cycle where the counter holds TMO_MAX-1. That cycle is the
    // TMO_MAX-th cycle spent in MEM_WAIT.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_MAX - 1);

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pc_q, res_q, wdata_q;
    logic              wen_q, redir_q, err_q, sticky_q;
    logic [TMO_W-1:0]  tmo_cnt_q;
    logic              accept;
    logic              tmo_hit;

    assign tmo_hit = (tmo_cnt_q == TMO_LAST);
    assign accept  = in_valid & in_ready;

    // Next-state and input-handshake decode.
    // A new instruction accepted in WB overrides the return to IDLE.
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        case (state_q)
            S_IDLE:     in_ready = 1'b1;
            S_MEM_REQ:  if (mem_req_ready) state_d = S_MEM_WAIT;
            S_MEM_WAIT: if (mem_rsp_valid || tmo_hit) state_d = S_WB;
            S_WB: begin
                if (out_ready) begin
                    in_ready = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default:    state_d = S_IDLE;
        endcase
        if (i_rst) begin
            in_ready = 1'b0;
        end
        if (in_ready && in_valid) begin
            state_d = (in_is_load || in_is_store) ? S_MEM_REQ : S_WB;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Instruction capture, memory result merge, and timeout bookkeeping.
    // When both flags are set the store wins, so a load response never
    // overwrites the address of such an instruction.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            pc_q      <= '0;
            res_q     <= '0;
            wdata_q   <= '0;
            wen_q     <= 1'b0;
            redir_q   <= 1'b0;
            err_q     <= 1'b0;
            sticky_q  <= 1'b0;
            tmo_cnt_q <= '0;
        end else if (accept) begin
            pc_q      <= in_pc;
            res_q     <= in_res;
            wdata_q   <= in_wdata;
            wen_q     <= in_is_store;
            redir_q   <= in_is_brch & in_brch_taken;
            err_q     <= 1'b0;
        end else begin
            case (state_q)
                S_MEM_REQ: begin
                    if (mem_req_ready) tmo_cnt_q <= '0;
                end
                S_MEM_WAIT: begin
                    if (mem_rsp_valid) begin
                        if (!wen_q) res_q <= mem_rsp_data;
                    end else if (tmo_hit) begin
                        res_q    <= '0;
                        err_q    <= 1'b1;
                        sticky_q <= 1'b1;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_req_valid = (state_q == S_MEM_REQ);
    assign mem_req_wen   = wen_q;
    assign mem_req_addr  = res_q;
    assign mem_req_wdata = wdata_q;

    assign out_valid     = (state_q == S_WB);
    assign out_pc        = pc_q;
    assign out_res       = res_q;
    assign out_redirect  = out_valid & redir_q;
    assign out_err       = out_valid & err_q;
    assign err_sticky    = sticky_q;

endmodule

// File: tb/tb_exu_seq_ctrl.sv
// Bench for exu_seq_ctrl. A transaction-level model follows the one
// instruction in flight and is compared against the DUT at every falling
// edge. Directed scenarios add hand-computed literal checks.
module tb_exu_seq_ctrl;
    localparam int XLEN    = 32;
    localparam int TMO_MAX = 4;

    logic            clk = 1'b0;
    logic            i_rst;
    logic            in_valid, in_ready;
    logic [XLEN-1:0] in_pc, in_res, in_wdata;
    logic            in_is_load, in_is_store, in_is_brch, in_brch_taken;
    logic            mem_req_valid, mem_req_ready, mem_req_wen;
    logic [XLEN-1:0] mem_req_addr, mem_req_wdata;
    logic            mem_rsp_valid;
    logic [XLEN-1:0] mem_rsp_data;
    logic            out_valid, out_ready;
    logic [XLEN-1:0] out_pc, out_res;
    logic            out_redirect, out_err, err_sticky;

    always #5 clk = ~clk;

    exu_seq_ctrl #(.XLEN(XLEN), .TMO_W(8), .TMO_MAX(TMO_MAX)) dut (
        .clk(clk), .i_rst(i_rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_res(in_res),
        .in_wdata(in_wdata), .in_is_load(in_is_load), .in_is_store(in_is_store),
        .in_is_brch(in_is_brch), .in_brch_taken(in_brch_taken),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_wen(mem_req_wen), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata), .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data(mem_rsp_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_res(out_res), .out_redirect(out_redirect), .out_err(out_err),
        .err_sticky(err_sticky)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model state: the instruction held, whether its request is still
    // outstanding, whether its response is awaited, and how long it waited.
    bit          m_have = 0, m_req = 0, m_wait = 0;
    int          m_waited = 0;
    logic [31:0] m_pc = 0, m_res = 0, m_wd = 0;
    bit          m_wen = 0, m_redir = 0, m_err = 0, m_sticky = 0;

    always @(negedge clk) begin : compare
        bit e_req, e_out, e_rdy;
        if (i_rst) begin
            chk("m_rst_in_ready", in_ready, 0);
            chk("m_rst_req_valid", mem_req_valid, 0);
            chk("m_rst_out_valid", out_valid, 0);
            chk("m_rst_redirect", out_redirect, 0);
            chk("m_rst_err", out_err, 0);
            chk("m_rst_sticky", err_sticky, 0);
            m_have = 0; m_req = 0; m_wait = 0; m_waited = 0;
            m_err = 0; m_redir = 0; m_sticky = 0;
        end else begin
            e_req = m_have && m_req;
            e_out = m_have && !m_req && !m_wait;
            e_rdy = !m_have || (e_out && out_ready);
            chk("m_in_ready", in_ready, e_rdy);
            chk("m_req_valid", mem_req_valid, e_req);
            chk("m_out_valid", out_valid, e_out);
            chk("m_redirect", out_redirect, e_out && m_redir);
            chk("m_out_err", out_err, e_out && m_err);
            chk("m_sticky", err_sticky, m_sticky);
            if (e_req) begin
                chk("m_req_addr", mem_req_addr, m_res);
                chk("m_req_wdata", mem_req_wdata, m_wd);
                chk("m_req_wen", mem_req_wen, m_wen);
            end
            if (e_out) begin
                chk("m_out_pc", out_pc, m_pc);
                chk("m_out_res", out_res, m_res);
            end
            // Advance the model to what must hold after the coming edge.
            if (m_have && m_req) begin
                if (mem_req_ready) begin
                    m_req = 0; m_wait = 1; m_waited = 0;
                end
            end else if (m_have && m_wait) begin
                if (mem_rsp_valid) begin
                    m_wait = 0;
                    if (!m_wen) m_res = mem_rsp_data;
                end else begin
                    m_waited++;
                    if (m_waited == TMO_MAX) begin
                        m_wait = 0; m_res = 0; m_err = 1; m_sticky = 1;
                    end
                end
            end else if (e_out && out_ready) begin
                m_have = 0;
            end
            if (in_valid && e_rdy) begin
                m_have  = 1;
                m_pc    = in_pc;
                m_res   = in_res;
                m_wd    = in_wdata;
                m_wen   = in_is_store;
                m_redir = in_is_brch && in_brch_taken;
                m_err   = 0;
                m_req   = in_is_load || in_is_store;
                m_wait  = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int k;
        i_rst = 1; in_valid = 0; in_pc = 0; in_res = 0; in_wdata = 0;
        in_is_load = 0; in_is_store = 0; in_is_brch = 0; in_brch_taken = 0;
        mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = 0; out_ready = 1;

        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        step(); i_rst = 0;
        step();

        // ALU op held valid for three cycles, one result per cycle.
        in_valid = 1; in_pc = 32'h8000_0000; in_res = 32'h0000_002A;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("alu_in_ready", in_ready, 1);
            if (i > 0) begin
                chk("alu_out_valid", out_valid, 1);
                chk("alu_out_res", out_res, 32'h0000_002A);
            end
            step();
            if (i == 2) in_valid = 0;
        end

        // Load, request accepted after 2 cycles, response 3 cycles later.
        mem_req_ready = 0; in_valid = 1; in_is_load = 1;
        in_pc = 32'h8000_0004; in_res = 32'h8000_0010;
        step(); in_valid = 0; in_is_load = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("ld_req_valid", mem_req_valid, 1);
            chk("ld_req_addr", mem_req_addr, 32'h8000_0010);
            chk("ld_req_wen", mem_req_wen, 0);
            step();
            if (i == 1) mem_req_ready = 1;
            if (i == 2) mem_req_ready = 0;
        end
        @(negedge clk);
        chk("ld_wait_req_valid", mem_req_valid, 0);
        step(); step();
        mem_rsp_valid = 1; mem_rsp_data = 32'hDEAD_BEEF;
        step(); mem_rsp_valid = 0;
        @(negedge clk);
        chk("ld_out_valid", out_valid, 1);
        chk("ld_out_res", out_res, 32'hDEAD_BEEF);
        chk("ld_out_err", out_err, 0);
        step();

        // Store with the load flag also set; a stray response in MEM_REQ.
        in_valid = 1; in_is_store = 1; in_is_load = 1;
        in_pc = 32'h8000_0008; in_res = 32'h8000_0020; in_wdata = 32'h1234_5678;
        step(); in_valid = 0; in_is_store = 0; in_is_load = 0;
        mem_rsp_valid = 1; mem_rsp_data = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("st_req_wen", mem_req_wen, 1);
        chk("st_req_wdata", mem_req_wdata, 32'h1234_5678);
        step(); mem_rsp_valid = 0; mem_req_ready = 1;
        @(negedge clk);
        chk("st_req_still_valid", mem_req_valid, 1);
        step(); mem_req_ready = 0;
        mem_rsp_valid = 1; mem_rsp_data = 32'hCAFE_0000;
        step(); mem_rsp_valid = 0;
        @(negedge clk);
        chk("st_out_valid", out_valid, 1);
        chk("st_out_res", out_res, 32'h8000_0020);
        step();

        // Taken branch stalled by WBU for 4 cycles, then back-to-back accept.
        out_ready = 0; in_valid = 1; in_is_brch = 1; in_brch_taken = 1;
        in_pc = 32'h8000_0100; in_res = 32'h8000_0200;
        step();
        in_is_brch = 0; in_brch_taken = 0; in_pc = 32'h8000_0104; in_res = 32'h0000_0007;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("br_out_valid", out_valid, 1);
            chk("br_out_pc", out_pc, 32'h8000_0100);
            chk("br_redirect", out_redirect, 1);
            chk("br_in_ready", in_ready, 0);
            step();
            if (i == 3) out_ready = 1;
        end
        @(negedge clk);
        chk("br_in_ready_release", in_ready, 1);
        step(); in_valid = 0;
        @(negedge clk);
        chk("b2b_out_pc", out_pc, 32'h8000_0104);
        chk("b2b_out_res", out_res, 32'h0000_0007);
        chk("b2b_redirect", out_redirect, 0);
        step();

        // Load that never gets a response.
        in_valid = 1; in_is_load = 1; in_pc = 32'h8000_000C; in_res = 32'h8000_0030;
        mem_req_ready = 1;
        step(); in_valid = 0; in_is_load = 0;
        step(); mem_req_ready = 0;
        k = 0;
        while (k < 20) begin
            @(negedge clk);
            if (out_valid) break;
            k++;
            step();
        end
        chk("tmo_wait_cycles", 32'(k), 32'd4);
        chk("tmo_out_err", out_err, 1);
        chk("tmo_out_res", out_res, 32'h0);
        chk("tmo_sticky", err_sticky, 1);
        step();
        in_valid = 1; in_pc = 32'h8000_0010; in_res = 32'h0000_0055;
        step(); in_valid = 0;
        @(negedge clk);
        chk("post_tmo_res", out_res, 32'h0000_0055);
        chk("post_tmo_err", out_err, 0);
        chk("post_tmo_sticky", err_sticky, 1);
        step();

        // Reset in the middle of a load's MEM_WAIT, then a stray response.
        in_valid = 1; in_is_load = 1; in_pc = 32'h8000_0014; in_res = 32'h8000_0040;
        mem_req_ready = 1;
        step(); in_valid = 0; in_is_load = 0;
        step(); mem_req_ready = 0;
        step();
        i_rst = 1;
        #1;
        chk("mrst_req_valid", mem_req_valid, 0);
        chk("mrst_out_valid", out_valid, 0);
        chk("mrst_sticky", err_sticky, 0);
        chk("mrst_in_ready", in_ready, 0);
        step(); i_rst = 0;
        mem_rsp_valid = 1; mem_rsp_data = 32'h1111_1111;
        step(); mem_rsp_valid = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stray_out_valid", out_valid, 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
